// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ALU with flags, iterative shifts and shift-add MUL,
//            fronted by valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             neg_flag,
    output logic             busy
);

    localparam int c_CW = SHW + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SLL  = 4'd3;
    localparam logic [3:0] c_OP_SUB  = 4'd4;
    localparam logic [3:0] c_OP_SRL  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_XOR  = 4'd7;
    localparam logic [3:0] c_OP_SRA  = 4'd8;
    localparam logic [3:0] c_OP_MUL  = 4'd9;
    localparam logic [3:0] c_OP_SLT  = 4'd10;

    localparam logic [c_CW-1:0] c_MUL_COUNT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;    // shift operand, or MUL multiplicand
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_amt;
    logic             w_is_shift;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_final;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state == c_EXEC);

    assign w_sum      = {1'b0, src_a} + {1'b0, src_b};
    assign w_diff     = {1'b0, src_a} - {1'b0, src_b};
    assign w_amt      = src_b[SHW-1:0];
    assign w_is_shift = (operation == c_OP_SLL) || (operation == c_OP_SRL) ||
                        (operation == c_OP_SRA);
    assign w_is_mul   = (operation == c_OP_MUL);

    // Single-cycle datapath; zero-amount shifts pass src_a straight through.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (operation)
            c_OP_AND: w_res = src_a & src_b;
            c_OP_OR:  w_res = src_a | src_b;
            c_OP_XOR: w_res = src_a ^ src_b;
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_OP_SLL, c_OP_SRL, c_OP_SRA: w_res = src_a;
            default:   w_res = '0;
        endcase
    end

    always_comb begin
        w_work_next = r_work;
        case (r_op)
            c_OP_SLL: w_work_next = r_work << 1;
            c_OP_SRL: w_work_next = r_work >> 1;
            c_OP_SRA: w_work_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            c_OP_MUL: w_work_next = r_work << 1;
            default:  w_work_next = r_work;
        endcase
        w_acc_next = r_mplier[0] ? (r_acc + r_work) : r_acc;
        w_final    = (r_op == c_OP_MUL) ? w_acc_next : w_work_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_work     <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            alu_result <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            neg_flag   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op <= operation;
                        if (w_is_mul) begin
                            r_count  <= c_MUL_COUNT;
                            r_acc    <= '0;
                            r_work   <= src_a;
                            r_mplier <= src_b;
                            r_state  <= c_EXEC;
                        end else if (w_is_shift && (w_amt != '0)) begin
                            r_count <= {1'b0, w_amt};
                            r_work  <= src_a;
                            r_state <= c_EXEC;
                        end else begin
                            alu_result <= w_res;
                            zero_flag  <= (w_res == '0);
                            carry_flag <= w_carry;
                            ovf_flag   <= w_ovf;
                            neg_flag   <= w_res[WIDTH-1];
                            r_state    <= c_DONE;
                        end
                    end
                end
                c_EXEC: begin
                    r_count  <= r_count - c_ONE;
                    r_work   <= w_work_next;
                    r_mplier <= r_mplier >> 1;
                    r_acc    <= w_acc_next;
                    if (r_count == c_ONE) begin
                        alu_result <= w_final;
                        zero_flag  <= (w_final == '0);
                        carry_flag <= 1'b0;
                        ovf_flag   <= 1'b0;
                        neg_flag   <= w_final[WIDTH-1];
                        r_state    <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Vector table, hand sequences and random ops for alu_seq (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [3:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero_flag;
    logic         carry_flag;
    logic         ovf_flag;
    logic         neg_flag;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // fl packs {zero, carry, ovf, neg}
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           lat;
    } rec_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .operation  (operation),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .ovf_flag   (ovf_flag),
        .neg_flag   (neg_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [3:0] fl, input int lat);
        rec_t r;
        r.op = op; r.a = a; r.b = b; r.res = res; r.fl = fl; r.lat = lat;
        return r;
    endfunction

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic rec_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        rec_t r;
        int ua, ub, sa, sb, s, full, n;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        n = int'(b[2:0]);
        full = 0; c = 1'b0; v = 1'b0;
        r.lat = 1;
        case (op)
            4'd0: full = ua & ub;
            4'd1: full = ua | ub;
            4'd2: begin full = ua + ub; c = (full > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            4'd3: begin full = ua << n; r.lat = n + 1; end
            4'd4: begin full = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
            4'd5: begin full = ua >> n; r.lat = n + 1; end
            4'd6: full = (ua < ub) ? 1 : 0;
            4'd7: full = ua ^ ub;
            4'd8: begin full = sa >>> n; r.lat = n + 1; end
            4'd9: begin full = ua * ub; r.lat = W + 1; end
            4'd10: full = (sa < sb) ? 1 : 0;
            default: full = 0;
        endcase
        r.op = op; r.a = a; r.b = b;
        r.res = full[W-1:0];
        r.fl = {(r.res == '0), c, v, r.res[W-1]};
        return r;
    endfunction

    // Issue one op from IDLE, scramble inputs while it runs, check, then consume.
    task automatic do_op(input rec_t r, input string tag);
        int cyc, bz;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; operation = r.op; src_a = r.a; src_b = r.b;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cyc = 1; bz = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) bz++;
            src_a = W'($urandom); src_b = W'($urandom); operation = 4'($urandom);
            @(negedge clk); cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(r.lat));
        check({tag, " busy_cycles"}, 32'(bz), 32'(r.lat - 1));
        check({tag, " result"}, 32'(alu_result), 32'(r.res));
        check({tag, " flags_zcvn"}, 32'({zero_flag, carry_flag, ovf_flag, neg_flag}), 32'(r.fl));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    rec_t vec[15];

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; operation = '0;

        vec[0]  = mk(4'd2,  8'h7F, 8'h01, 8'h80, 4'b0011, 1);
        vec[1]  = mk(4'd2,  8'hFF, 8'h01, 8'h00, 4'b1100, 1);
        vec[2]  = mk(4'd4,  8'h03, 8'h05, 8'hFE, 4'b0101, 1);
        vec[3]  = mk(4'd6,  8'h03, 8'h05, 8'h01, 4'b0000, 1);
        vec[4]  = mk(4'd10, 8'h80, 8'h01, 8'h01, 4'b0000, 1);
        vec[5]  = mk(4'd6,  8'h80, 8'h01, 8'h00, 4'b1000, 1);
        vec[6]  = mk(4'd3,  8'h01, 8'h05, 8'h20, 4'b0000, 6);
        vec[7]  = mk(4'd8,  8'h80, 8'h03, 8'hF0, 4'b0001, 4);
        vec[8]  = mk(4'd5,  8'h80, 8'h00, 8'h80, 4'b0001, 1);
        vec[9]  = mk(4'd9,  8'h0D, 8'h0B, 8'h8F, 4'b0001, 9);
        vec[10] = mk(4'd9,  8'h10, 8'h10, 8'h00, 4'b1000, 9);
        vec[11] = mk(4'd0,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
        vec[12] = mk(4'd1,  8'hF0, 8'h3C, 8'hFC, 4'b0001, 1);
        vec[13] = mk(4'd7,  8'hF0, 8'h3C, 8'hCC, 4'b0001, 1);
        vec[14] = mk(4'd4,  8'h80, 8'h01, 8'h7F, 4'b0010, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", 32'(alu_result), 32'd0);
        check("reset flags", 32'({zero_flag, carry_flag, ovf_flag, neg_flag}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_op(vec[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and a pending in_valid must wait.
        in_valid = 1'b1; operation = 4'd2; src_a = 8'h12; src_b = 8'h34;
        @(posedge clk); @(negedge clk);
        operation = 4'd7; src_a = 8'hFF; src_b = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d result", i), 32'(alu_result), 32'h46);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("bp next out_valid", 32'(out_valid), 32'd1);
        check("bp next result", 32'(alu_result), 32'hF0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;

        // Reset during MUL at cycle 4 must abort with no result.
        in_valid = 1'b1; operation = 4'd9; src_a = 8'h0D; src_b = 8'h0B;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 4) begin
            @(negedge clk); cyc++;
        end
        check("mid-mul busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort result", 32'(alu_result), 32'd0);
        check("abort zero", 32'(zero_flag), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("abort stays quiet", 32'(out_valid), 32'd0);
        end
        do_op(mk(4'd12, 8'h5A, 8'hA5, 8'h00, 4'b1000, 1), "reserved12");

        for (int i = 0; i < 150; i++) begin
            do_op(model(4'($urandom), W'($urandom), W'($urandom)), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
